// File: rtl/mcuspi_bridge.sv
// MCU SPI slave bridge: framed SPI (command, address, data words) to single-cycle register strobes.
// Define MCUSPI_RD_EN to build the read path (RDATA state, MISO drive); otherwise reads are errors.
module mcuspi_bridge #(
  parameter int unsigned DW     = 8,
  parameter int unsigned AW     = 16,
  parameter int unsigned NCH    = 2,
  parameter int unsigned RD_LAT = 1,
  localparam int unsigned CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk_sys,
  input  logic           rst,
  input  logic [NCH-1:0] mcu_csn,
  input  logic           mcu_sck,
  input  logic           mcu_mosi,
  output logic           mcu_miso,
  output logic           mcu_miso_oe,
  output logic           reg_wr,
  output logic [AW-1:0]  reg_waddr,
  output logic [DW-1:0]  reg_data,
  output logic           reg_rd,
  output logic [AW-1:0]  reg_raddr,
  input  logic [DW-1:0]  reg_q,
  output logic [CW-1:0]  reg_ch,
  output logic           frm_err
);
  localparam int unsigned SW       = (DW > AW) ? DW : AW;
  localparam logic [5:0]  CmdLast  = 6'd7;
  localparam logic [5:0]  AddrLast = 6'(AW - 1);
  localparam logic [5:0]  DataLast = 6'(DW - 1);
  localparam logic [2:0]  LatInit  = 3'(RD_LAT);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StWData, StRData, StErr} state_e;

  logic [NCH-1:0] csn_m, csn_s;
  logic           sck_m, sck_s, sck_q, mosi_m, mosi_s;

  // csn sync flops reset low so a chip select held low through reset cannot arm the FSM.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      csn_m  <= '0;
      csn_s  <= '0;
      sck_m  <= 1'b0;
      sck_s  <= 1'b0;
      sck_q  <= 1'b0;
      mosi_m <= 1'b0;
      mosi_s <= 1'b0;
    end else begin
      csn_m  <= mcu_csn;
      csn_s  <= csn_m;
      sck_m  <= mcu_sck;
      sck_s  <= sck_m;
      sck_q  <= sck_s;
      mosi_m <= mcu_mosi;
      mosi_s <= mosi_m;
    end
  end

  state_e         state_q;
  logic           armed_q, rnw_q, ainc_q, wr_q, rd_q, err_q, miso_q, oe_q;
  logic [CW-1:0]  ch_q;
  logic [5:0]     cnt_q;
  logic [SW-2:0]  rx_q;
  logic [AW-1:0]  waddr_q, raddr_q;
  logic [DW-1:0]  wdata_q, tx_q, rdq_w;
  logic [2:0]     lat_q;

  logic           sck_rise, sck_fall, all_high, abort, active;
  logic [NCH-1:0] low_mask, act_mask;
  logic [CW-1:0]  low_idx;
  logic [SW-1:0]  shift_word;

  assign sck_rise   = sck_s & ~sck_q;
  assign sck_fall   = ~sck_s & sck_q;
  assign low_mask   = ~csn_s;
  assign all_high   = &csn_s;
  assign shift_word = {rx_q, mosi_s};
  assign active     = state_q inside {StCmd, StAddr, StWData, StRData};

  always_comb begin
    act_mask          = '0;
    act_mask[ch_q]    = 1'b1;
    low_idx           = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (low_mask[i]) low_idx = CW'(i);
    end
  end

  // Active csn released, or any other csn pulled low, ends the frame.
  assign abort = (low_mask != act_mask);

`ifdef MCUSPI_RD_EN
  localparam bit RdEn = 1'b1;
  assign rdq_w       = reg_q;
  assign reg_rd      = rd_q;
  assign mcu_miso    = miso_q & oe_q;
  assign mcu_miso_oe = oe_q;
`else
  localparam bit RdEn = 1'b0;
  logic unused_rd;
  assign rdq_w       = '0;
  assign reg_rd      = 1'b0;
  assign mcu_miso    = 1'b0;
  assign mcu_miso_oe = 1'b0;
  assign unused_rd   = ^{reg_q, rd_q, miso_q, oe_q};
`endif

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= StIdle;
      armed_q <= 1'b0;
      ch_q    <= '0;
      cnt_q   <= '0;
      rx_q    <= '0;
      rnw_q   <= 1'b0;
      ainc_q  <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      waddr_q <= '0;
      raddr_q <= '0;
      wdata_q <= '0;
      tx_q    <= '0;
      lat_q   <= '0;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      err_q <= 1'b0;
      oe_q  <= 1'b0;
      if (sck_rise) rx_q <= shift_word[SW-2:0];
      if (wr_q && ainc_q) waddr_q <= waddr_q + AW'(1);
      if (rd_q && ainc_q) raddr_q <= raddr_q + AW'(1);
      if (rd_q) lat_q <= LatInit;
      else if (lat_q != '0) lat_q <= lat_q - 3'd1;
      if (lat_q == 3'd1) tx_q <= rdq_w;
      if (state_q != StRData) miso_q <= 1'b0;

      if (active && abort) begin
        state_q <= StIdle;
        err_q   <= (state_q == StAddr) || ((state_q == StCmd) && (cnt_q != '0));
      end else begin
        unique case (state_q)
          StIdle: begin
            if (all_high) begin
              armed_q <= 1'b1;
            end else if (armed_q) begin
              armed_q <= 1'b0;
              cnt_q   <= '0;
              if ($countones(low_mask) == 1) begin
                state_q <= StCmd;
                ch_q    <= low_idx;
              end else begin
                state_q <= StErr;
                err_q   <= 1'b1;
              end
            end
          end
          StCmd: begin
            if (sck_rise) begin
              if (cnt_q == CmdLast) begin
                cnt_q  <= '0;
                rnw_q  <= shift_word[7];
                ainc_q <= shift_word[6];
                if (shift_word[7] && !RdEn) begin
                  state_q <= StErr;
                  err_q   <= 1'b1;
                end else begin
                  state_q <= StAddr;
                end
              end else begin
                cnt_q <= cnt_q + 6'd1;
              end
            end
          end
          StAddr: begin
            if (sck_rise) begin
              if (cnt_q == AddrLast) begin
                cnt_q <= '0;
                if (rnw_q) begin
                  raddr_q <= shift_word[AW-1:0];
                  rd_q    <= 1'b1;
                  state_q <= StRData;
                end else begin
                  waddr_q <= shift_word[AW-1:0];
                  state_q <= StWData;
                end
              end else begin
                cnt_q <= cnt_q + 6'd1;
              end
            end
          end
          StWData: begin
            if (sck_rise) begin
              if (cnt_q == DataLast) begin
                cnt_q   <= '0;
                wdata_q <= shift_word[DW-1:0];
                wr_q    <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 6'd1;
              end
            end
          end
          StRData: begin
            oe_q <= 1'b1;
            if (sck_fall) begin
              miso_q <= tx_q[DW-1];
              tx_q   <= {tx_q[DW-2:0], 1'b0};
            end
            // Last bit of a word: prefetch the next word so its MSB is ready for the next fall.
            if (sck_rise) begin
              if (cnt_q == DataLast) begin
                cnt_q <= '0;
                rd_q  <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 6'd1;
              end
            end
          end
          StErr: begin
            if (all_high) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign reg_wr    = wr_q;
  assign reg_waddr = waddr_q;
  assign reg_data  = wdata_q;
  assign reg_raddr = raddr_q;
  assign reg_ch    = ch_q;
  assign frm_err   = err_q;

endmodule

// File: tb/tb_mcuspi_bridge.sv
// Bench for mcuspi_bridge: directed frames plus random write frames against a transaction-level model.
module tb_mcuspi_bridge;
  localparam int unsigned DW = 8, AW = 16, NCH = 2, RD_LAT = 1, CW = 1, HP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic [NCH-1:0] mcu_csn = '1;
  logic           mcu_sck = 1'b0, mcu_mosi = 1'b0;
  logic           mcu_miso, mcu_miso_oe, reg_wr, reg_rd, frm_err;
  logic [AW-1:0]  reg_waddr, reg_raddr;
  logic [DW-1:0]  reg_data;
  logic [DW-1:0]  reg_q = '0;
  logic [CW-1:0]  reg_ch;

  int checks = 0, errors = 0;

  mcuspi_bridge #(.DW(DW), .AW(AW), .NCH(NCH), .RD_LAT(RD_LAT)) dut (
    .clk_sys(clk), .rst(rst), .mcu_csn(mcu_csn), .mcu_sck(mcu_sck), .mcu_mosi(mcu_mosi),
    .mcu_miso(mcu_miso), .mcu_miso_oe(mcu_miso_oe), .reg_wr(reg_wr), .reg_waddr(reg_waddr),
    .reg_data(reg_data), .reg_rd(reg_rd), .reg_raddr(reg_raddr), .reg_q(reg_q),
    .reg_ch(reg_ch), .frm_err(frm_err)
  );

  // Register file stand-in: returns addr[7:0] exactly one cycle after reg_rd, junk otherwise.
  always @(posedge clk) reg_q <= reg_rd ? DW'(reg_raddr[7:0]) : DW'(8'hEE);

  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  logic [CW-1:0] wc_q[$];
  logic [AW-1:0] ra_q[$];
  int   err_cnt = 0, oe_cnt = 0, both_cnt = 0, long_cnt = 0;
  logic wr_p = 1'b0, err_p = 1'b0;

  always @(negedge clk) begin
    if (reg_wr === 1'b1) begin
      wa_q.push_back(reg_waddr);
      wd_q.push_back(reg_data);
      wc_q.push_back(reg_ch);
    end
    if (reg_rd === 1'b1) ra_q.push_back(reg_raddr);
    if (frm_err === 1'b1 && !err_p) err_cnt++;
    if ((frm_err === 1'b1 && err_p) || (reg_wr === 1'b1 && wr_p)) long_cnt++;
    if (reg_wr === 1'b1 && reg_rd === 1'b1) both_cnt++;
    if (mcu_miso_oe === 1'b1) oe_cnt++;
    wr_p  = (reg_wr === 1'b1);
    err_p = (frm_err === 1'b1);
  end

  logic [DW-1:0] tx_words[8];
  logic [DW-1:0] rx_words[8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    wa_q.delete(); wd_q.delete(); wc_q.delete(); ra_q.delete();
    err_cnt = 0; oe_cnt = 0;
  endtask

  task automatic spi_bits(input logic [31:0] v, input int n, output logic [31:0] r);
    r = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mcu_mosi = v[i];
      wait_clk(HP);
      r = {r[30:0], mcu_miso};
      mcu_sck = 1'b1;
      wait_clk(HP);
      mcu_sck = 1'b0;
    end
  endtask

  task automatic cs_on(input int ch);
    mcu_csn[ch] = 1'b0;
    wait_clk(2 * HP);
  endtask

  task automatic cs_off();
    mcu_mosi = 1'b0;
    wait_clk(HP);
    mcu_csn = '1;
    wait_clk(2 * HP);
  endtask

  task automatic frame(input int ch, input logic [7:0] cmd, input logic [AW-1:0] addr,
                       input int nw);
    logic [31:0] r;
    cs_on(ch);
    spi_bits(32'(cmd), 8, r);
    spi_bits(32'(addr), AW, r);
    for (int i = 0; i < nw; i++) begin
      spi_bits(32'(tx_words[i]), DW, r);
      rx_words[i] = r[DW-1:0];
    end
    cs_off();
  endtask

  // Expected: word i lands at (addr + i) mod 2^AW with auto-increment, else at addr.
  task automatic chk_writes(input string t, input int ch, input logic [AW-1:0] addr,
                            input bit ainc, input int nw);
    int unsigned ea;
    chk({t, "_nwr"}, wa_q.size(), nw);
    for (int i = 0; i < nw && i < wa_q.size(); i++) begin
      ea = (int'(addr) + (ainc ? i : 0)) % (1 << AW);
      chk({t, "_addr"}, 32'(wa_q[i]), ea);
      chk({t, "_data"}, 32'(wd_q[i]), 32'(tx_words[i]));
      chk({t, "_ch"}, 32'(wc_q[i]), ch);
    end
    chk({t, "_err"}, err_cnt, 0);
  endtask

  task automatic chk_idle_outputs(input string t);
    chk({t, "_wr"}, 32'(reg_wr), 0);
    chk({t, "_rd"}, 32'(reg_rd), 0);
    chk({t, "_err"}, 32'(frm_err), 0);
    chk({t, "_miso"}, 32'(mcu_miso), 0);
    chk({t, "_oe"}, 32'(mcu_miso_oe), 0);
    chk({t, "_waddr"}, 32'(reg_waddr), 0);
    chk({t, "_raddr"}, 32'(reg_raddr), 0);
    chk({t, "_data"}, 32'(reg_data), 0);
    chk({t, "_ch"}, 32'(reg_ch), 0);
  endtask

  initial begin
    logic [31:0]   r;
    logic [AW-1:0] a;
    bit            ainc;
    int            ch, nw;

    wait_clk(3);
    chk_idle_outputs("rst_hold");
    rst = 1'b0;
    wait_clk(4);
    chk_idle_outputs("rst_idle");
    clr();

    tx_words[0] = 8'hA5; tx_words[1] = 8'h5A;
    frame(0, 8'h40, 16'h0010, 2);
    chk_writes("wr_ainc", 0, 16'h0010, 1'b1, 2);
    clr();

    for (int i = 0; i < 3; i++) tx_words[i] = DW'($urandom);
    frame(1, 8'h00, 16'hFFFF, 3);
    chk_writes("wr_fixed", 1, 16'hFFFF, 1'b0, 3);
    clr();
    frame(1, 8'h40, 16'hFFFF, 3);
    chk_writes("wr_wrap", 1, 16'hFFFF, 1'b1, 3);
    clr();

    cs_on(0);
    spi_bits(32'h40, 8, r);
    spi_bits(32'h15, 5, r);
    cs_off();
    chk("abort_addr_err", err_cnt, 1);
    chk("abort_addr_nwr", wa_q.size(), 0);
    clr();

    cs_on(0);
    spi_bits(32'h00, 8, r);
    spi_bits(32'h1234, AW, r);
    spi_bits(32'h5, 3, r);
    cs_off();
    chk("abort_data_err", err_cnt, 0);
    chk("abort_data_nwr", wa_q.size(), 0);
    clr();

    mcu_csn = '0;
    wait_clk(2 * HP);
    spi_bits(32'h4000_3C, 32, r);
    cs_off();
    chk("multi_cs_err", err_cnt, 1);
    chk("multi_cs_nwr", wa_q.size() + ra_q.size(), 0);
    clr();

    cs_on(1);
    spi_bits(32'h40, 8, r);
    spi_bits(32'h1234, AW, r);
    spi_bits(32'h77, DW, r);
    spi_bits(32'h3, 3, r);
    chk("pre_rst_nwr", wa_q.size(), 1);
    rst = 1'b1;
    wait_clk(2);
    chk_idle_outputs("mid_rst");
    rst = 1'b0;
    clr();
    spi_bits(32'h1F, 5, r);
    spi_bits(32'hC3, DW, r);
    cs_off();
    chk("post_rst_nwr", wa_q.size(), 0);
    chk("post_rst_err", err_cnt, 0);
    clr();
    tx_words[0] = 8'h3C; tx_words[1] = 8'hC3;
    frame(0, 8'h40, 16'h0100, 2);
    chk_writes("rst_recover", 0, 16'h0100, 1'b1, 2);
    clr();

`ifdef MCUSPI_RD_EN
    tx_words[0] = '0; tx_words[1] = '0;
    frame(0, 8'hC0, 16'h0020, 2);
    chk("rd_miso0", 32'(rx_words[0]), 32'h20);
    chk("rd_miso1", 32'(rx_words[1]), 32'h21);
    chk("rd_nrd", ra_q.size(), 3);
    for (int i = 0; i < 3 && i < ra_q.size(); i++) chk("rd_addr", 32'(ra_q[i]), 32'h20 + i);
    chk("rd_oe_seen", 32'(oe_cnt != 0), 1);
    chk("rd_err", err_cnt, 0);
    chk("rd_nwr", wa_q.size(), 0);
`else
    tx_words[0] = '0;
    frame(0, 8'h80, 16'h0020, 1);
    chk("rd_off_err", err_cnt, 1);
    chk("rd_off_oe", oe_cnt, 0);
    chk("rd_off_nrd", ra_q.size(), 0);
    chk("rd_off_nwr", wa_q.size(), 0);
`endif
    chk("rd_end_oe", 32'(mcu_miso_oe), 0);
    clr();

    for (int k = 0; k < 12; k++) begin
      ch   = int'($urandom_range(0, NCH - 1));
      ainc = 1'($urandom);
      a    = AW'($urandom);
      nw   = int'($urandom_range(1, 4));
      for (int i = 0; i < nw; i++) tx_words[i] = DW'($urandom);
      frame(ch, {1'b0, ainc, 6'($urandom)}, a, nw);
      chk_writes("rand", ch, a, ainc, nw);
      clr();
    end

    chk("never_wr_and_rd", both_cnt, 0);
    chk("pulses_one_cycle", long_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
